// File: rtl/wb_bram_bist.sv
// Wishbone pipelined BRAM self-test master: writes (addr ^ SEED) to every
// address, reads everything back and reports pass/fail, timeout and first bad address.
module wb_bram_bist #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          AUTO_START  = 1'b1,
  parameter int unsigned START_DELAY = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_start,
  output logic                                 o_wb_cyc,
  output logic                                 o_wb_stb,
  output logic                                 o_wb_we,
  output logic [AW-1:0]                        o_wb_addr,
  output logic [DW-1:0]                        o_wb_data,
  output logic [((DW/8 > 1) ? DW/8 : 1)-1:0]   o_wb_sel,
  input  logic                                 i_wb_stall,
  input  logic                                 i_wb_ack,
  input  logic [DW-1:0]                        i_wb_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_pass,
  output logic                                 o_timeout,
  output logic [7:0]                           o_err_count,
  output logic [AW-1:0]                        o_fail_addr,
  output logic [5:0]                           o_led,
  output logic [2:0]                           o_dbg_state
);

  localparam int unsigned PW   = (AW > 8) ? AW : 8;
  localparam int unsigned TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned DLW  = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
  localparam int unsigned HB_W = 23;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      err_q, err_d;
  logic [AW-1:0]   fail_q, fail_d;
  logic            timeout_q, timeout_d;
  logic [DLW-1:0]  dly_q, dly_d;
  logic            armed_q, armed_d;
  logic [HB_W-1:0] hb_q;

  logic [PW-1:0]   pat_wide;
  logic [DW-1:0]   exp_data;
  logic            last_addr;
  logic            ack_expired;
  logic            auto_go;
  logic            go;

  assign pat_wide    = PW'(addr_q) ^ PW'(SEED);
  assign exp_data    = DW'(pat_wide);
  assign last_addr   = (addr_q == '1);
  assign ack_expired = (tcnt_q == TW'(TIMEOUT - 1));
  // Auto-start is a one-shot armed by reset; any start (manual or auto) disarms it.
  assign auto_go     = AUTO_START && armed_q && (dly_q == DLW'(START_DELAY));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    armed_d   = armed_q;
    dly_d     = dly_q;
    go        = 1'b0;

    if (dly_q != DLW'(START_DELAY)) dly_d = dly_q + DLW'(1);

    case (state_q)
      IDLE:    go = i_start || auto_go;
      WR_REQ, RD_REQ: begin
        if (!i_wb_stall) begin
          state_d = (state_q == WR_REQ) ? WR_ACK : RD_ACK;
          tcnt_d  = '0;
        end
      end
      WR_ACK, RD_ACK: begin
        if (i_wb_ack) begin
          if (state_q == RD_ACK && i_wb_data != exp_data) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'd0) fail_d = addr_q;
          end
          if (state_q == WR_ACK) begin
            state_d = RD_REQ;
            addr_d  = last_addr ? '0 : addr_q + AW'(1);
            if (!last_addr) state_d = WR_REQ;
          end else begin
            state_d = last_addr ? DONE : RD_REQ;
            if (!last_addr) addr_d = addr_q + AW'(1);
          end
        end else if (ack_expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DONE:    go = i_start;
      default: state_d = IDLE;
    endcase

    if (go) begin
      state_d   = WR_REQ;
      addr_d    = '0;
      err_d     = '0;
      fail_d    = '0;
      timeout_d = 1'b0;
      armed_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tcnt_q    <= '0;
      err_q     <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      dly_q     <= '0;
      armed_q   <= AUTO_START;
      hb_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      dly_q     <= dly_d;
      armed_q   <= armed_d;
      hb_q      <= hb_q + HB_W'(1);
    end
  end

  // Bus outputs decode straight from registered state, so reset drops cyc/stb at once.
  assign o_wb_cyc    = (state_q == WR_REQ) || (state_q == WR_ACK) ||
                       (state_q == RD_REQ) || (state_q == RD_ACK);
  assign o_wb_stb    = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign o_wb_we     = (state_q == WR_REQ) || (state_q == WR_ACK);
  assign o_wb_addr   = o_wb_cyc ? addr_q : '0;
  assign o_wb_data   = o_wb_cyc ? exp_data : '0;
  assign o_wb_sel    = o_wb_cyc ? '1 : '0;
  assign o_busy      = o_wb_cyc;
  assign o_done      = (state_q == DONE);
  assign o_pass      = o_done && (err_q == 8'd0) && !timeout_q;
  assign o_timeout   = timeout_q;
  assign o_err_count = err_q;
  assign o_fail_addr = fail_q;
  assign o_led       = {err_q != 8'd0, timeout_q, o_pass, o_done, o_busy, hb_q[HB_W-1]};
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wb_bram_bist.sv
// Directed + randomized bench for wb_bram_bist (AW=4) with a behavioural
// Wishbone slave and a spec-level model of the expected results.
module tb_wb_bram_bist;
  localparam int          AW   = 4;
  localparam int          DW   = 8;
  localparam int          N    = 16;
  localparam int          TMO  = 255;
  localparam int          SDLY = 16;
  localparam logic [7:0]  SEED = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cyc, stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [0:0]    sel;
  logic          stall = 1'b0;
  logic          ack = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          busy, done, pass, tmo;
  logic [7:0]    errc;
  logic [AW-1:0] faddr;
  logic [5:0]    led;
  logic [2:0]    dbg;

  int          checks = 0;
  int          failures = 0;
  int unsigned edge_n = 0;

  // slave configuration
  int          stall_fixed = 0;
  int          stall_max = 0;
  logic [N-1:0] corrupt = '0;
  int          noack_addr = -1;

  // slave state
  logic [7:0]    mem [N];
  bit            req_seen = 0;
  bit            acc_pending = 0;
  int            stall_left = 0;
  int unsigned   stall_total = 0;
  bit            noack_hit = 0;
  int unsigned   noack_edge = 0;
  logic [AW-1:0] h_addr, a_addr;
  logic          h_we, a_we;
  logic [7:0]    h_data, a_data;

  wb_bram_bist #(.AW(AW), .DW(DW), .SEED(SEED), .TIMEOUT(TMO),
                 .AUTO_START(1'b1), .START_DELAY(SDLY)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr),
    .o_wb_data(wdata), .o_wb_sel(sel), .i_wb_stall(stall), .i_wb_ack(ack),
    .i_wb_data(rdata), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_timeout(tmo), .o_err_count(errc), .o_fail_addr(faddr), .o_led(led),
    .o_dbg_state(dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return 8'(a) ^ SEED;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave decisions are made on the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0; stall = 1'b0; req_seen = 0; acc_pending = 0;
    end else begin
      ack = 1'b0;
      if (acc_pending) begin
        acc_pending = 0;
        if (a_we) begin
          chk("wr_data", 32'(a_data), 32'(pat(a_addr)));
          mem[a_addr] = a_data;
          if (noack_addr == int'(a_addr)) begin
            noack_hit = 1; noack_edge = edge_n;
          end else ack = 1'b1;
        end else begin
          rdata = mem[a_addr] ^ (corrupt[a_addr] ? 8'($urandom_range(1, 255)) : 8'h00);
          ack = 1'b1;
        end
      end
      stall = 1'b0;
      if (stb) begin
        if (!req_seen) begin
          req_seen = 1; h_addr = addr; h_we = we; h_data = wdata;
          stall_left = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, stall_max));
        end else begin
          chk("stall_addr", 32'(addr), 32'(h_addr));
          chk("stall_we", 32'(we), 32'(h_we));
          chk("stall_data", 32'(wdata), 32'(h_data));
        end
        if (stall_left > 0) begin
          stall = 1'b1; stall_left--; stall_total++;
        end else begin
          req_seen = 0; acc_pending = 1; a_addr = addr; a_we = we; a_data = wdata;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(output int unsigned k);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    k = edge_n;
  endtask

  task automatic wait_edge(input int unsigned target);
    while (edge_n < target) tick();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"}, 32'({cyc, stb, we, addr, wdata, sel}), 32'd0);
    chk({tag, "_stat"}, 32'({busy, done, pass, tmo, errc, faddr, led}), 32'd0);
  endtask

  initial begin
    int unsigned k, a;
    int n, exp_err, exp_fail, bad;

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Ideal slave
    pulse_start(k);
    chk("t1_first_req", 32'({busy, stb, we, addr, wdata}), 32'({1'b1, 1'b1, 1'b1, 4'd0, 8'hA5}));
    wait_edge(k + 63);
    chk("t1_done_early", 32'(done), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_result", 32'({pass, tmo, errc, faddr}), 32'({1'b1, 1'b0, 8'd0, 4'd0}));
    chk("t1_led", 32'(led[5:1]), 32'b00110);
    chk("t1_mem3", 32'(mem[3]), 32'hA6);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== (8'(i) ^ SEED)) bad++;
    chk("t1_mem_all", 32'(bad), 32'd0);

    // Two stall cycles per request
    stall_fixed = 2; stall_total = 0;
    pulse_start(k);
    wait_edge(k + 127);
    chk("t2_done_early", 32'(done), 32'd0);
    tick();
    chk("t2_done", 32'({done, pass, errc}), 32'({1'b1, 1'b1, 8'd0}));
    chk("t2_stalls", stall_total, 32'd64);

    // Corrupt reads at 5 and 9, plus a start pulse while busy
    stall_fixed = 0; corrupt = '0; corrupt[5] = 1'b1; corrupt[9] = 1'b1;
    pulse_start(k);
    wait_edge(k + 50);
    chk("t3_err_mid", 32'(errc), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_busy_start", 32'({busy, errc, faddr}), 32'({1'b1, 8'd1, 4'd5}));
    wait_edge(k + 63);
    chk("t3_done_early", 32'(done), 32'd0);
    tick();
    chk("t3_result", 32'({done, pass, errc, faddr}), 32'({1'b1, 1'b0, 8'd2, 4'd5}));
    chk("t3_led_err", 32'(led[5]), 32'd1);

    // Start in DONE clears results; clean rerun passes
    corrupt = '0;
    pulse_start(k);
    chk("t3b_cleared", 32'({busy, done, pass, tmo, errc, faddr}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0}));
    wait_done(100, "t3b_done");
    chk("t3b_pass", 32'({pass, errc}), 32'({1'b1, 8'd0}));

    // Slave never acks the write to address 2
    noack_addr = 2; noack_hit = 0;
    pulse_start(k);
    n = 0;
    while (!noack_hit && n < 50) begin tick(); n++; end
    chk("t4_noack_seen", 32'(noack_hit), 32'd1);
    a = noack_edge;
    chk("t4_accept_edge", a, k + 5);
    wait_edge(a + TMO - 1);
    chk("t4_before", 32'({tmo, done, cyc}), 32'({1'b0, 1'b0, 1'b1}));
    tick();
    chk("t4_timeout", 32'({tmo, done, cyc, pass}), 32'({1'b1, 1'b1, 1'b0, 1'b0}));
    chk("t4_led", 32'(led[5:1]), 32'b01010);
    noack_addr = -1;

    // Randomized stalls and corruption against the model
    for (int r = 0; r < 5; r++) begin
      stall_fixed = -1;
      stall_max = int'($urandom_range(0, 3));
      corrupt = (r == 0) ? '0 : (N'($urandom) & N'($urandom));
      exp_err = 0; exp_fail = 0;
      for (int i = N - 1; i >= 0; i--) if (corrupt[i]) begin exp_err++; exp_fail = i; end
      stall_total = 0;
      pulse_start(k);
      wait_done(40 * N, "rnd_done");
      chk("rnd_done_edge", edge_n, k + 64 + stall_total);
      chk("rnd_err", 32'(errc), 32'(exp_err));
      chk("rnd_fail", 32'(faddr), 32'(exp_fail));
      chk("rnd_pass", 32'(pass), 32'(exp_err == 0));
    end
    corrupt = '0;

    // Reset during RD_ACK at address 7, then auto-start
    stall_fixed = 0;
    pulse_start(k);
    n = 0;
    while (!(cyc && !stb && !we && addr == 4'd7) && n < 200) begin tick(); n++; end
    chk("t5_reached_rdack7", 32'({cyc, stb, we, addr}), 32'({1'b1, 1'b0, 1'b0, 4'd7}));
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async_reset");
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (!busy && n < SDLY + 20) begin tick(); n++; end
    chk("t5_autostart", 32'({busy, stb, we, addr}), 32'({1'b1, 1'b1, 1'b1, 4'd0}));
    chk("t5_not_early", 32'(n >= SDLY), 32'd1);
    wait_done(100, "t5_done");
    chk("t5_pass", 32'({pass, tmo, errc}), 32'({1'b1, 1'b0, 8'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_bram_bist.md
Name: wb_bram_bist

Overview:
- Wishbone pipelined bus master that sits directly upstream of the dual-port BRAM on the board top level.
- On start, writes a deterministic pattern to every BRAM address, then reads every address back and compares.
- Reports busy/done/pass/timeout, error count and first failing address; a 6-bit LED status vector feeds the board LEDs.

Parameters:
- AW, 8, address width; test covers addresses 0 .. 2^AW-1.
- DW, 8, data width.
- SEED, 8'hA5, pattern seed; expected data = (addr XOR SEED) truncated/zero-extended to DW.
- TIMEOUT, 255, maximum cycles to wait for ack after request acceptance.
- AUTO_START, 1, if 1, the block self-starts START_DELAY cycles after reset release.
- START_DELAY, 16, auto-start delay in cycles.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle start pulse; ignored while busy
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  AW  address
- o_wb_data  out  DW  write data
- o_wb_sel  out  DW/8 (min 1)  byte selects, all ones
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave acknowledge
- i_wb_data  in  DW  read data
- o_busy  out  1  test running
- o_done  out  1  test finished; held until next start
- o_pass  out  1  valid when o_done: no mismatches and no timeout
- o_timeout  out  1  ack timeout occurred
- o_err_count  out  8  mismatch count, saturates at 255
- o_fail_addr  out  AW  address of first mismatch; 0 if none
- o_led  out  6  {err_count!=0, timeout, pass, done, busy, heartbeat}

Behaviour:
- Reset: all outputs 0. State IDLE, address 0, delay counter 0. Reset may assert mid-transaction: cyc/stb drop asynchronously and no partial state is retained.
- States: IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, DONE.
- IDLE:
  - i_start=1 at edge k moves to WR_REQ with address 0; o_busy=1 and o_wb_stb=1 in cycle k+1.
  - With AUTO_START=1, the same transition fires when the post-reset delay counter reaches START_DELAY. Auto-start fires once per reset only.
- *_REQ: cyc=1, stb=1, we=1 (WR) or 0 (RD), addr = current address, data = expected pattern.
  - Request accepted on a cycle with stb=1 and i_wb_stall=0; then move to the matching *_ACK state with stb=0.
  - Address, data and we stay stable while stalled.
- *_ACK:
  - Timeout counter clears on entry and increments each cycle.
  - On i_wb_ack:
    - WR_ACK: at the last address, go to RD_REQ with address 0; otherwise go to WR_REQ with address+1.
    - RD_ACK: compare i_wb_data to the expected pattern. On mismatch, increment err_count (saturating); if err_count was 0, latch fail_addr. At the last address go to DONE; otherwise go to RD_REQ with address+1.
  - Ack is sampled only in ACK states; acks in REQ states are ignored, since a compliant slave never acks in the accept cycle.
  - If the counter reaches TIMEOUT without an ack: set o_timeout, go to DONE.
- cyc: held high continuously from the first WR_REQ through the final ack; it is 0 in IDLE and DONE.
- DONE:
  - busy=0, done=1, pass = (err_count==0 && !timeout).
  - i_start clears done/pass/timeout/err_count/fail_addr and restarts at WR_REQ address 0.
  - i_start while busy has no effect.
- Timing with zero stall and ack one cycle after accept: 2 cycles per transaction. With start sampled at edge k, the last ack is at k+2^(AW+2) and o_done=1 from cycle k+2^(AW+2)+1.
- Heartbeat: bit 0 of o_led toggles every 2^22 cycles from a free-running counter that is reset to 0.

Test Plan:
- AW=4, ideal slave (no stall, ack 1 cycle after accept, correct memory): pulse i_start at edge 10 -> 16 writes then 16 reads. Address 3 is written with 8'hA6. o_done=1 at cycle 75, o_pass=1, o_err_count=0.
- Slave stalls 2 cycles on every request -> same results; addr/data/we stable during stall; done at cycle 10+32*4+1 = 139.
- Slave corrupts read data at addresses 5 and 9 -> o_pass=0, o_err_count=2, o_fail_addr=5.
- Slave never acks the write to address 2 -> o_timeout=1 exactly TIMEOUT cycles after acceptance; cyc=0, o_pass=0, o_done=1.
- Reset pulsed during RD_ACK at address 7 -> all outputs 0 immediately. With AUTO_START=1, the test restarts from address 0 after START_DELAY cycles and passes.
- i_start pulsed while busy -> no effect on address or counters. i_start in DONE after a failing run -> counters cleared and a clean rerun passes.
